// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and redirect helper for the IF fetch stage.
// Optional feature macro: IF_ALIGN_EXC_EN (misaligned fetch raises if_excp_adel).
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD = '0;
    localparam logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int unsigned STALL_IF_ID = 1;
    localparam int unsigned STALL_ID    = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_e;

    // Without alignment exceptions every redirect is snapped to a word boundary.
    function automatic logic [INST_ADDR_W-1:0] redirect_pc(input logic [INST_ADDR_W-1:0] target);
`ifdef IF_ALIGN_EXC_EN
        return target;
`else
        return {target[INST_ADDR_W-1:2], 2'b00};
`endif
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: request FSM, PC, pending-branch register and IF/ID hold buffer.
// Optional feature macro: IF_ALIGN_EXC_EN (misaligned PC offered with if_excp_adel=1, no request).
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if,
    output logic        if_excp_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_vld_q, pend_vld_d;
    logic [31:0]  disc_pc_q, disc_pc_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_inst_q, buf_inst_d;
`ifdef IF_ALIGN_EXC_EN
    logic         buf_adel_q, buf_adel_d;
`endif

    logic         adel_now;
    logic         fetch_hit;
    logic         valid;
    logic         consume;
    logic         branch_take;
    logic [31:0]  flush_pc;
    logic [31:0]  branch_pc;
    logic [31:0]  next_pc;
    logic [7:0]   unused_bits;

    assign unused_bits = {stall[5:3], stall[0], new_pc[1:0], branch_target_i[1:0]};

`ifdef IF_ALIGN_EXC_EN
    assign adel_now = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
`else
    assign adel_now = 1'b0;
`endif

    assign fetch_hit   = (state_q == S_REQ) && (adel_now || inst_ack);
    assign consume     = valid && (stall[STALL_IF_ID] == NO_STOP);
    assign branch_take = branch_flag_i && (stall[STALL_ID] == NO_STOP);
    assign flush_pc    = redirect_pc(new_pc);
    assign branch_pc   = redirect_pc(branch_target_i);

    always_comb begin
        inst_req     = 1'b0;
        inst_addr    = ZERO_WORD;
        if_pc        = ZERO_WORD;
        if_inst      = ZERO_WORD;
        if_excp_adel = 1'b0;
        valid        = 1'b0;
        case (state_q)
            S_REQ: begin
                if (adel_now) begin
                    valid        = 1'b1;
                    if_pc        = pc_q;
                    if_excp_adel = 1'b1;
                end else begin
                    inst_req  = 1'b1;
                    inst_addr = pc_q;
                    if (inst_ack) begin
                        valid   = 1'b1;
                        if_pc   = pc_q;
                        if_inst = inst_rdata;
                    end
                end
            end
            S_HOLD: begin
                valid   = 1'b1;
                if_pc   = buf_pc_q;
                if_inst = buf_inst_q;
`ifdef IF_ALIGN_EXC_EN
                if_excp_adel = buf_adel_q;
`endif
            end
            S_DISCARD: begin
                inst_req  = 1'b1;
                inst_addr = pc_q;
            end
            default: ;
        endcase
        stallreq_if = ~valid;
    end

    always_comb begin
        if (branch_take) begin
            next_pc = branch_pc;
        end else if (pend_vld_q) begin
            next_pc = pend_pc_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_vld_d = pend_vld_q;
        disc_pc_d  = disc_pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
`ifdef IF_ALIGN_EXC_EN
        buf_adel_d = buf_adel_q;
`endif
        if (flush) begin
            pend_vld_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // An unacked request cannot be withdrawn, so it is drained in DISCARD.
                    if (fetch_hit) begin
                        pc_d = flush_pc;
                    end else begin
                        disc_pc_d = flush_pc;
                        state_d   = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (inst_ack) begin
                        pc_d    = flush_pc;
                        state_d = S_REQ;
                    end else begin
                        disc_pc_d = flush_pc;
                    end
                end
                default: begin
                    pc_d    = flush_pc;
                    state_d = S_REQ;
                end
            endcase
        end else begin
            if (branch_take && !consume) begin
                pend_vld_d = 1'b1;
                pend_pc_d  = branch_pc;
            end
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (fetch_hit) begin
                        if (consume) begin
                            pc_d       = next_pc;
                            pend_vld_d = 1'b0;
                        end else begin
                            buf_pc_d   = pc_q;
                            buf_inst_d = adel_now ? ZERO_WORD : inst_rdata;
`ifdef IF_ALIGN_EXC_EN
                            buf_adel_d = adel_now;
`endif
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        pc_d       = next_pc;
                        pend_vld_d = 1'b0;
                        state_d    = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (inst_ack) begin
                        pc_d    = disc_pc_q;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_pc_q  <= ZERO_WORD;
            pend_vld_q <= 1'b0;
            disc_pc_q  <= ZERO_WORD;
            buf_pc_q   <= ZERO_WORD;
            buf_inst_q <= ZERO_WORD;
`ifdef IF_ALIGN_EXC_EN
            buf_adel_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_vld_q <= pend_vld_d;
            disc_pc_q  <= disc_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
`ifdef IF_ALIGN_EXC_EN
            buf_adel_q <= buf_adel_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; memory model answers zero-wait or under manual ack.
// Honours IF_ALIGN_EXC_EN for the misaligned-branch scenario.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush;
    logic [31:0] new_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;
    logic        if_excp_adel;

    logic        ack_mode;
    logic        ack_manual;
    logic        saw_18;
    int          n_checks;
    int          n_fail;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .flush          (flush),
        .new_pc         (new_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_ack       (inst_ack),
        .inst_rdata     (inst_rdata),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .stallreq_if    (stallreq_if),
        .if_excp_adel   (if_excp_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always_comb begin
        inst_ack   = ack_mode ? ack_manual : inst_req;
        inst_rdata = inst_req ? rd(inst_addr) : 32'h0;
    end

    always @(negedge clk) begin
        if (inst_req && inst_addr == 32'h18) saw_18 = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush = 1'b0; new_pc = '0; ack_mode = 1'b0; ack_manual = 1'b0; saw_18 = 1'b0;
        #1;
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL rst_inst_req: got %b want 0", inst_req); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL rst_inst_addr: got %h want 0", inst_addr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
        n_checks++; if (if_excp_adel !== 1'b0) begin n_fail++; $display("FAIL rst_adel: got %b want 0", if_excp_adel); end
        n_checks++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL rst_stallreq: got %b want 1", stallreq_if); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL idle_stallreq: got %b want 1", stallreq_if); end
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL idle_inst_req: got %b want 0", inst_req); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(i * 4);
            tick();
            n_checks++; if (if_pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
            n_checks++; if (if_inst !== rd(exp_pc)) begin n_fail++; $display("FAIL seq_inst[%0d]: got %h want %h", i, if_inst, rd(exp_pc)); end
            n_checks++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL seq_stallreq[%0d]: got %b want 0", i, stallreq_if); end
        end
    endtask

    task automatic test_hold();
        stall = 6'b000010;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b want 0", k, inst_req); end
            n_checks++; if (if_pc !== 32'h8) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want 00000008", k, if_pc); end
            n_checks++; if (if_inst !== rd(32'h8)) begin n_fail++; $display("FAIL hold_inst[%0d]: got %h want %h", k, if_inst, rd(32'h8)); end
            n_checks++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL hold_stallreq[%0d]: got %b want 0", k, stallreq_if); end
        end
        stall = '0;
        tick();
        n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL post_hold_req: got %b want 1", inst_req); end
        n_checks++; if (inst_addr !== 32'hC) begin n_fail++; $display("FAIL post_hold_addr: got %h want 0000000c", inst_addr); end
    endtask

    task automatic test_branch();
        tick();
        n_checks++; if (if_pc !== 32'h10) begin n_fail++; $display("FAIL br_pc10: got %h want 00000010", if_pc); end
        tick();
        n_checks++; if (if_pc !== 32'h14) begin n_fail++; $display("FAIL br_slot: got %h want 00000014", if_pc); end
        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        tick();
        branch_flag_i = 1'b0;
        n_checks++; if (inst_addr !== 32'h40) begin n_fail++; $display("FAIL br_target_addr: got %h want 00000040", inst_addr); end
        n_checks++; if (if_pc !== 32'h40) begin n_fail++; $display("FAIL br_target_pc: got %h want 00000040", if_pc); end
        tick();
        n_checks++; if (if_pc !== 32'h44) begin n_fail++; $display("FAIL br_after: got %h want 00000044", if_pc); end
        n_checks++; if (saw_18 !== 1'b0) begin n_fail++; $display("FAIL br_no_18: got %b want 0", saw_18); end
    endtask

    task automatic test_pending_branch();
        stall = 6'b000010; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        tick();
        branch_flag_i = 1'b0;
        n_checks++; if (if_pc !== 32'h44) begin n_fail++; $display("FAIL pend_hold_pc: got %h want 00000044", if_pc); end
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL pend_hold_req: got %b want 0", inst_req); end
        stall = '0;
        tick();
        n_checks++; if (if_pc !== 32'h80) begin n_fail++; $display("FAIL pend_target: got %h want 00000080", if_pc); end
    endtask

    task automatic test_flush_discard();
        ack_mode = 1'b1; ack_manual = 1'b0;
        flush = 1'b1; new_pc = 32'h180;
        #1;
        n_checks++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL fl_noack_stall: got %b want 1", stallreq_if); end
        n_checks++; if (inst_addr !== 32'h80) begin n_fail++; $display("FAIL fl_orig_addr: got %h want 00000080", inst_addr); end
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL disc_req[%0d]: got %b want 1", k, inst_req); end
            n_checks++; if (inst_addr !== 32'h80) begin n_fail++; $display("FAIL disc_addr[%0d]: got %h want 00000080", k, inst_addr); end
            if (k < 2) tick();
        end
        ack_manual = 1'b1;
        #1;
        n_checks++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL disc_drop_stall: got %b want 1", stallreq_if); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL disc_drop_pc: got %h want 0", if_pc); end
        tick();
        ack_manual = 1'b0;
        n_checks++; if (inst_addr !== 32'h180) begin n_fail++; $display("FAIL disc_new_addr: got %h want 00000180", inst_addr); end
        n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL disc_new_req: got %b want 1", inst_req); end
        ack_mode = 1'b0;
        #1;
        n_checks++; if (if_pc !== 32'h180) begin n_fail++; $display("FAIL disc_new_pc: got %h want 00000180", if_pc); end
        tick();
        n_checks++; if (if_pc !== 32'h184) begin n_fail++; $display("FAIL disc_next_pc: got %h want 00000184", if_pc); end
    endtask

    task automatic test_misaligned();
        branch_flag_i = 1'b1; branch_target_i = 32'h42;
        tick();
        branch_flag_i = 1'b0;
`ifdef IF_ALIGN_EXC_EN
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL adel_req: got %b want 0", inst_req); end
        n_checks++; if (if_excp_adel !== 1'b1) begin n_fail++; $display("FAIL adel_flag: got %b want 1", if_excp_adel); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL adel_inst: got %h want 0", if_inst); end
        n_checks++; if (if_pc !== 32'h42) begin n_fail++; $display("FAIL adel_pc: got %h want 00000042", if_pc); end
        n_checks++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL adel_stall: got %b want 0", stallreq_if); end
        flush = 1'b1; new_pc = 32'h100;
        tick();
        flush = 1'b0;
        n_checks++; if (inst_addr !== 32'h100) begin n_fail++; $display("FAIL adel_recover: got %h want 00000100", inst_addr); end
`else
        n_checks++; if (inst_addr !== 32'h40) begin n_fail++; $display("FAIL align_br_addr: got %h want 00000040", inst_addr); end
        n_checks++; if (if_excp_adel !== 1'b0) begin n_fail++; $display("FAIL align_adel: got %b want 0", if_excp_adel); end
        flush = 1'b1; new_pc = 32'h203;
        tick();
        flush = 1'b0;
        n_checks++; if (inst_addr !== 32'h200) begin n_fail++; $display("FAIL align_flush_addr: got %h want 00000200", inst_addr); end
`endif
    endtask

    task automatic test_reset_mid();
        ack_mode = 1'b1; ack_manual = 1'b0;
        tick();
        n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL rm_outstanding: got %b want 1", inst_req); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", inst_req); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 0", inst_addr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rm_pc: got %h want 0", if_pc); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rm_inst: got %h want 0", if_inst); end
        n_checks++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL rm_stall: got %b want 1", stallreq_if); end
        @(negedge clk);
        rst = 1'b1; ack_mode = 1'b0;
        tick();
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL rm_refetch_addr: got %h want 0", inst_addr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rm_refetch_pc: got %h want 0", if_pc); end
        tick();
        n_checks++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL rm_refetch_next: got %h want 00000004", if_pc); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sequential();
        test_hold();
        test_branch();
        test_pending_branch();
        test_flush_discard();
        test_misaligned();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; assertion clears state immediately, release is synchronous to clk.
REQ-003 stall  in  6  pipeline stall vector from ctrl; bit 1 = IF/ID hold, bit 2 = ID hold; `Stop/`NoStop encoding.
REQ-004 branch_flag_i / branch_target_i  in  1/32  taken branch leaving ID, with its target.
REQ-005 flush / new_pc  in  1/32  exception redirect and its vector.
REQ-006 inst_req / inst_addr  out  1/32  fetch request to instruction memory, with word address.
REQ-007 inst_ack / inst_rdata  in  1/32  memory accepts the request and returns data in the same cycle; zero-wait ack is legal.
REQ-008 if_pc / if_inst  out  32/32  PC and instruction offered to the IF/ID register.
REQ-009 stallreq_if  out  1  no valid instruction is offered this cycle.
REQ-010 if_excp_adel  out  1  offered instruction carries a fetch address error (see Configuration).

Function
REQ-011 FSM states: IDLE, REQ, HOLD, DISCARD.
- IDLE → REQ unconditionally on the first edge after reset release.
REQ-012 inst_req=1 in REQ and DISCARD only; inst_addr=pc while inst_req=1, otherwise `ZeroWord.
- Once raised, inst_req and inst_addr are held stable until an edge samples inst_ack=1; no withdrawal.
REQ-013 Valid instruction offered when:
- REQ & inst_ack: if_pc=pc, if_inst=inst_rdata (combinational bypass).
- HOLD: if_pc/if_inst from the 32+32 buffer.
- Otherwise: if_pc=if_inst=`ZeroWord and stallreq_if=1.
REQ-014 Consume = valid & stall[1]==`NoStop at a rising edge.
- pc <= next_pc; state REQ; the next request is issued in the following cycle.
- With zero-wait memory the block sustains one instruction per cycle.
REQ-015 REQ & inst_ack & stall[1]==`Stop: capture pc/inst_rdata into the buffer; go to HOLD.
- HOLD issues no request; the buffered instruction is consumed when stall[1] releases.
REQ-016 next_pc priority, highest first:
- flush → new_pc
- branch_flag_i & stall[2]==`NoStop this edge → branch_target_i
- pend_vld → pend_pc
- else pc+4, 32-bit wrap (0xFFFFFFFC → 0x00000000).
REQ-017 Branch seen on an edge with no consume sets pend_vld/pend_pc. The pending target applies after the next consume (the delay slot); pend_vld clears on that consume.
REQ-018 flush, any state; pend_vld cleared:
- REQ without ack → DISCARD; latch new_pc.
- REQ with ack, or HOLD → drop the instruction; pc <= new_pc; REQ.
REQ-019 DISCARD holds the outstanding request until inst_ack, drops inst_rdata, then goes REQ at the latched pc. A further flush in DISCARD overwrites the latched pc.
REQ-020 No instruction is ever offered twice or skipped except as dropped by REQ-018/019.

Reset
REQ-021 While rst=0: state IDLE, pc=0x00000000, pend_vld=0, buffer=`ZeroWord.
- Outputs: inst_req=0, inst_addr=0, if_pc=0, if_inst=0, if_excp_adel=0, stallreq_if=1.
REQ-022 Reset during an outstanding request abandons it; memory is required to tolerate an abandoned request.

Configuration
REQ-023 Macro IF_ALIGN_EXC_EN.
- Defined: in REQ with pc[1:0]!=0, no request is issued; the instruction is offered immediately with if_inst=`ZeroWord, if_pc=pc, if_excp_adel=1, and consume follows REQ-014.
- Undefined: if_excp_adel is tied 0 and every redirect target is forced word-aligned (bits [1:0]=00).

Structure
REQ-024 defines.v holds InstAddrBus, InstBus, ZeroWord, Stop/NoStop, ResetPC (0x00000000) and state encodings.
REQ-025 No sub-module: FSM, PC, pending-branch and buffer registers live in one file.

Verification
REQ-026 Zero-wait memory, no stalls, from reset: if_pc sequence 0x0,0x4,0x8 on consecutive cycles; stallreq_if=0 from the second cycle after release.
REQ-027 inst_ack at pc=0x8 with stall[1]=Stop for 3 cycles: HOLD; inst_req=0; if_inst stable; consumed on release; next inst_addr=0xC.
REQ-028 Branch at 0x10 with target 0x40: delay slot 0x14 is offered, then 0x40; 0x18 is never requested.
REQ-029 Ack delayed 4 cycles, flush with new_pc=0x180 in cycle 1: request at its original address held to ack, data dropped, next inst_addr=0x180.
REQ-030 IF_ALIGN_EXC_EN defined, branch target 0x42: no request at 0x42; if_excp_adel=1, if_inst=0.
REQ-031 rst low mid-request: all outputs go to reset values immediately; after release, refetch from 0x00000000.
